// File: rtl/filter_accel_mul_arb_pkg.sv
// filter_accel_mul_arb_pkg: shared widths and helpers for the shared-multiplier arbiter.
package filter_accel_mul_arb_pkg;
  localparam int DEF_A_W = 8;
  localparam int DEF_B_W = 10;
  localparam int DEF_P_W = 18;
  localparam int STAT_W  = 16;
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/filter_accel_mul_arb_rr.sv
// filter_accel_mul_arb_rr: round-robin grant picker, first valid at or after ptr modulo N.
module filter_accel_mul_arb_rr #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vld_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    // Walk from farthest to nearest so the slot closest to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      logic [IW-1:0] j;
      j = IW'((int'(ptr_i) + k) % N);
      if (vld_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end
endmodule

// File: rtl/filter_accel_mul_arb.sv
// filter_accel_mul_arb: round-robin share of one 2-stage signed x unsigned multiplier.
// Optional per-requester transfer counters under FILTER_MUL_ARB_STATS_EN.
module filter_accel_mul_arb
  import filter_accel_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int P_W     = DEF_P_W,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
`ifdef FILTER_MUL_ARB_STATS_EN
  input  logic                      stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt,
`endif
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*A_W-1:0]    req_a,
  input  logic [NUM_REQ*B_W-1:0]    req_b,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      rsp_vld,
  output logic [ID_W-1:0]           rsp_id,
  output logic signed [P_W-1:0]     rsp_p
);
  logic [NUM_REQ-1:0] vld_m, gnt;
  logic [ID_W-1:0]    gnt_idx, ptr_q, ptr_d, id1_q;
  logic [A_W-1:0]     a_sel, a1_q;
  logic [B_W-1:0]     b_sel, b1_q;
  logic               xfer, v1_q;
  logic signed [P_W-1:0] prod;
  assign vld_m = (arb_en && ap_rst_n) ? req_vld : '0;
  filter_accel_mul_arb_rr #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .vld_i(vld_m),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx)
  );
  assign req_rdy = gnt;
  assign xfer    = |gnt;
  assign ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_sel = a_sel | (gnt[i] ? req_a[i*A_W +: A_W] : '0);
      b_sel = b_sel | (gnt[i] ? req_b[i*B_W +: B_W] : '0);
    end
  end
  // b is zero-extended so the product is a signed-by-nonnegative multiply.
  assign prod = P_W'($signed(a1_q)) * P_W'($signed({1'b0, b1_q}));
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q   <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      id1_q   <= '0;
      v1_q    <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_p   <= '0;
    end else begin
      if (xfer) begin
        ptr_q <= ptr_d;
        a1_q  <= a_sel;
        b1_q  <= b_sel;
        id1_q <= gnt_idx;
      end
      v1_q    <= xfer;
      rsp_vld <= v1_q;
      if (v1_q) begin
        rsp_id <= id1_q;
        rsp_p  <= prod;
      end
    end
  end
`ifdef FILTER_MUL_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        cnt_q[i] <= stat_clr ? '0 : (gnt[i] && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
  end
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
  end
`endif
endmodule
